// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and line constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } uart_state_e;

    localparam logic UART_IDLE_LVL        = 1'b1;
    localparam int   DATA_BITS            = 8;
    localparam int   DEF_CLKS_PER_BIT     = 1085;  // 125 MHz / 115200

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run_i is high and pulses
// tick_o on the last count of each bit period. Dropping run_i clears it.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Free-run within a frame, wrap on the tick, park at zero when stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (!run_i || cnt_q == LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

    assign tick_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 transmit serializer draining the print FIFO (non-FWFT, 1-cycle read
// latency) onto the TX pin, with active-low CTS flow control checked per byte.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter bit CTS_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty_i,
    input  logic [7:0]  fifo_dout_i,
    output logic        fifo_rden_o,
    input  logic        uart_cts_i,
    output logic        uart_tx_o,
    output logic        tx_busy_o,
    output logic [31:0] tx_byte_cnt_o
);

    uart_state_e              state_q, state_d;
    logic                     cts_meta_q, cts_n_s;
    logic [DATA_BITS-1:0]     shift_q;
    logic [2:0]               bit_idx_q;
    logic                     stop_idx_q;
    logic                     tx_q;
    logic [31:0]              byte_cnt_q;
    logic                     baud_run, baud_tick;
    logic                     cts_ok, stop_last, pop;

    // CTS comes straight from the host connector; resync and default to "not clear".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_meta_q <= 1'b1;
            cts_n_s    <= 1'b1;
        end else begin
            cts_meta_q <= uart_cts_i;
            cts_n_s    <= cts_meta_q;
        end
    end

    assign cts_ok    = !CTS_EN || !cts_n_s;
    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
    assign baud_run  = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .run_i  (baud_run),
        .tick_o (baud_tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and pop strobe; the pop is held off while reset is asserted.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && !fifo_empty_i && cts_ok) begin
                    pop     = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD:  state_d = START;
            START: if (baud_tick) state_d = DATA;
            DATA:  if (baud_tick && bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
            STOP:  if (baud_tick && stop_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the popped byte, then present one bit per baud tick, LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= UART_IDLE_LVL;
        end else begin
            case (state_q)
                LOAD: begin
                    shift_q    <= fifo_dout_i;
                    bit_idx_q  <= '0;
                    stop_idx_q <= 1'b0;
                    tx_q       <= ~UART_IDLE_LVL;
                end
                START: if (baud_tick) tx_q <= shift_q[0];
                DATA: begin
                    if (baud_tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        tx_q      <= (bit_idx_q == 3'(DATA_BITS - 1)) ? UART_IDLE_LVL : shift_q[1];
                    end
                end
                STOP: if (baud_tick) stop_idx_q <= ~stop_idx_q;
                default: tx_q <= UART_IDLE_LVL;
            endcase
        end
    end

    // Count a byte only once its final stop bit has completed; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            byte_cnt_q <= '0;
        else if (state_q == STOP && baud_tick && stop_last)
            byte_cnt_q <= byte_cnt_q + 32'd1;
    end

    assign fifo_rden_o   = pop;
    assign uart_tx_o     = tx_q;
    assign tx_busy_o     = (state_q != IDLE);
    assign tx_byte_cnt_o = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench: three engines (1 stop / 2 stop / CTS ignored) fed by small FIFO models.
module tb_uart_tx_engine;

    localparam int CPB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst, cts_n, rden, tx, busy, empty;
    logic [7:0]  dout [3];
    logic [31:0] cnt  [3];
    logic [7:0]  mem  [3][16];
    int          wr [3] = '{default: 0};
    int          rd [3] = '{default: 0};
    int          n_chk = 0, n_pass = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_engine #(
            .CLKS_PER_BIT (CPB),
            .STOP_BITS    ((g == 1) ? 2 : 1),
            .CTS_EN       ((g == 2) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk           (clk),
            .rst           (rst[g]),
            .fifo_empty_i  (empty[g]),
            .fifo_dout_i   (dout[g]),
            .fifo_rden_o   (rden[g]),
            .uart_cts_i    (cts_n[g]),
            .uart_tx_o     (tx[g]),
            .tx_busy_o     (busy[g]),
            .tx_byte_cnt_o (cnt[g])
        );
    end

    // Non-FWFT FIFO models: data appears the cycle after the pop.
    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (rden[i]) begin
                dout[i] <= mem[i][rd[i] % 16];
                rd[i]   <= rd[i] + 1;
            end

    always_comb begin
        empty = '0;
        for (int i = 0; i < 3; i++) empty[i] = (wr[i] == rd[i]);
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(int i, logic [7:0] b);
        mem[i][wr[i] % 16] = b;
        wr[i]++;
    endtask

    // Step negedges until the pop strobe is seen; n = negedges waited.
    task automatic wait_rden(int i, int lim, string tag, output int n);
        n = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            n++;
            if (rden[i]) break;
        end
        chk({tag, " rden"}, rden[i], 1);
    endtask

    // Called on the negedge of the pop cycle; walks the whole frame.
    task automatic chk_frame(int i, logic [7:0] b, int sb, string tag);
        logic [11:0] e;
        int bad, busy_n, rd_n;
        e = '1; e[0] = 1'b0; e[8:1] = b;
        bad = (tx[i] !== 1'b1) ? 1 : 0;
        busy_n = 0; rd_n = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (tx[i] !== 1'b1) bad++;
            busy_n += int'(busy[i]); rd_n += int'(rden[i]);
        end
        for (int k = 0; k < 9 + sb; k++)
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx[i] !== e[k]) bad++;
                busy_n += int'(busy[i]); rd_n += int'(rden[i]);
            end
        chk({tag, " wave"}, bad, 0);
        chk({tag, " busy_len"}, busy_n, 2 + CPB * (9 + sb));
        chk({tag, " rden_in_frame"}, rd_n, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, bad;
        rst   = '1;
        cts_n = 3'b100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst tx", tx, 3'b111);
        chk("rst rden", rden, 0);
        chk("rst busy", busy, 0);
        chk("rst cnt0", cnt[0], 0);
        @(posedge clk); #1 rst = '0;
        repeat (4) @(negedge clk);

        // 1: single byte
        @(posedge clk); #1 push(0, 8'hA5);
        wait_rden(0, 20, "t1", n);
        chk_frame(0, 8'hA5, 1, "t1");
        @(negedge clk);
        chk("t1 busy_end", busy[0], 0);
        chk("t1 cnt", cnt[0], 1);
        chk("t1 pops", rd[0], 1);

        // 2: back-to-back, 3-cycle gap
        @(posedge clk); #1 push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
        wait_rden(0, 20, "t2a", n);
        chk_frame(0, 8'h00, 1, "t2a");
        wait_rden(0, 20, "t2b", n);
        chk("t2b gap", n, 1);
        chk_frame(0, 8'hFF, 1, "t2b");
        wait_rden(0, 20, "t2c", n);
        chk("t2c gap", n, 1);
        chk_frame(0, 8'h55, 1, "t2c");
        @(negedge clk);
        chk("t2 busy_end", busy[0], 0);
        chk("t2 cnt", cnt[0], 4);
        chk("t2 pops", rd[0], 4);

        // 3: CTS not clear blocks the pop
        cts_n[0] = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 push(0, 8'h3C);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || rden[0]) bad++;
        end
        chk("t3 blocked", bad, 0);
        @(posedge clk); #1 cts_n[0] = 1'b0;
        wait_rden(0, 10, "t3", n);
        chk("t3 cts_latency", n, 3);
        chk_frame(0, 8'h3C, 1, "t3");
        @(negedge clk);
        chk("t3 cnt", cnt[0], 5);

        // 4: CTS raised mid-frame
        @(posedge clk); #1 push(0, 8'h11); push(0, 8'h22);
        wait_rden(0, 20, "t4a", n);
        fork
            chk_frame(0, 8'h11, 1, "t4a");
            begin repeat (30) @(negedge clk); cts_n[0] = 1'b1; end
        join
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (rden[0] || busy[0] || tx[0] !== 1'b1) bad++;
        end
        chk("t4 held", bad, 0);
        chk("t4 cnt_mid", cnt[0], 6);
        @(posedge clk); #1 cts_n[0] = 1'b0;
        wait_rden(0, 10, "t4b", n);
        chk("t4 cts_latency", n, 3);
        chk_frame(0, 8'h22, 1, "t4b");
        @(negedge clk);
        chk("t4 cnt", cnt[0], 7);

        // 5: two stop bits, then reset mid-frame
        @(posedge clk); #1 push(1, 8'h96);
        wait_rden(1, 20, "t5a", n);
        chk_frame(1, 8'h96, 2, "t5a");
        @(negedge clk);
        chk("t5 cnt", cnt[1], 1);
        @(posedge clk); #1 push(1, 8'hA5);
        wait_rden(1, 20, "t5b", n);
        repeat (2 + CPB + CPB * 3 + 4) @(negedge clk);
        chk("t5 bit3", tx[1], 0);
        #1 rst[1] = 1'b1;
        #1;
        chk("t5 rst_tx", tx[1], 1);
        chk("t5 rst_busy", busy[1], 0);
        chk("t5 rst_cnt", cnt[1], 0);
        @(posedge clk); @(posedge clk); #1 rst[1] = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (rden[1] || busy[1] || tx[1] !== 1'b1) bad++;
        end
        chk("t5 no_resend", bad, 0);
        chk("t5 pops", rd[1], 2);

        // 6: CTS ignored, counter wrap
        @(posedge clk); #1 push(2, 8'hC3);
        wait_rden(2, 20, "t6a", n);
        chk_frame(2, 8'hC3, 1, "t6a");
        @(negedge clk);
        chk("t6 cnt", cnt[2], 1);
        force g_dut[2].u_dut.byte_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1 release g_dut[2].u_dut.byte_cnt_q;
        @(negedge clk);
        chk("t6 cnt_max", cnt[2], 32'hFFFF_FFFF);
        @(posedge clk); #1 push(2, 8'h81);
        wait_rden(2, 20, "t6b", n);
        chk_frame(2, 8'h81, 1, "t6b");
        @(negedge clk);
        chk("t6 cnt_wrap", cnt[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
